// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: bus widths, RV32I opcodes,
// ALU operation encodings and the layout of the ID->EX bundle.
package id_stage_pkg;

  localparam int IF_ID_BUS  = 64;
  localparam int ID_EX_BUS  = 146;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // Field order is MSB first; the struct is exactly ID_EX_BUS bits wide.
  typedef struct packed {
    logic        illegal;
    alu_op_e     alu_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic [2:0]  funct3;
    logic        mem_re;
    logic        mem_we;
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [31:0] rs1_data;
    logic [31:0] pc;
  } id_ex_bus_t;

  // Maps funct3 to an ALU operation; alt selects SUB/SRA where applicable.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, and write-to-read bypass for WB.
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [31:0]           rdata1,
  output logic [31:0]           rdata2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [31:0]           wdata
);

  logic [31:0] regs [0:31];

  // Register storage; x0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: x0 forced to zero, and a same-cycle WB write is forwarded.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage of the 5-stage RV32I core: holds the instruction from IF,
// decodes it, reads the register file and hands the bundle to EX.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fs_to_ds_valid,
  output logic                 ds_allowin,
  input  logic [IF_ID_BUS-1:0] if_id_bus_in,
  input  logic                 es_allowin,
  output logic                 ds_to_es_valid,
  output logic [ID_EX_BUS-1:0] id_ex_bus_out,
  input  logic                 flush,
  input  logic [4:0]           es_dest,
  input  logic [4:0]           ms_dest,
  input  logic                 ws_rf_we,
  input  logic [4:0]           ws_rf_waddr,
  input  logic [31:0]          ws_rf_wdata
);

  logic                 ds_valid;
  logic [IF_ID_BUS-1:0] fs_to_ds_bus_r;
  logic                 ds_ready_go;
  logic                 hazard;

  logic [31:0] inst;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_used;
  logic        rs2_used;
  logic        op_funct7_ok;

  id_ex_bus_t  ex_bus;

  assign inst   = fs_to_ds_bus_r[63:32];
  assign pc     = fs_to_ds_bus_r[31:0];
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Only funct7 = 0000000, or 0100000 with ADD/SUB and SRL/SRA, exists on OP.
  assign op_funct7_ok = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  // Stall while a source register is still being produced in EX or MEM.
  assign hazard = (rs1_used && (rs1 != 5'd0) && ((rs1 == es_dest) || (rs1 == ms_dest))) ||
                  (rs2_used && (rs2 != 5'd0) && ((rs2 == es_dest) || (rs2 == ms_dest)));

  assign ds_ready_go    = !hazard;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go && !flush;
  assign id_ex_bus_out  = ex_bus;

  // Stage valid bit: a flush kills the held instruction and any arriving one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_valid <= 1'b0;
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
    end
  end

  // Stage bus register; holds its contents under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_to_ds_bus_r <= '0;
    end else if (fs_to_ds_valid && ds_allowin && !flush) begin
      fs_to_ds_bus_r <= if_id_bus_in;
    end
  end

  id_stage_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (ws_rf_we),
    .waddr  (ws_rf_waddr),
    .wdata  (ws_rf_wdata)
  );

  // Instruction decode: control fields, immediate selection and operand usage.
  always_comb begin
    ex_bus.illegal     = 1'b0;
    ex_bus.alu_op      = ALU_ADD;
    ex_bus.src1_is_pc  = 1'b0;
    ex_bus.src2_is_imm = 1'b0;
    ex_bus.funct3      = funct3;
    ex_bus.mem_re      = 1'b0;
    ex_bus.mem_we      = 1'b0;
    ex_bus.rf_we       = 1'b0;
    ex_bus.rd          = rd;
    ex_bus.imm         = '0;
    ex_bus.rs2_data    = rs2_data;
    ex_bus.rs1_data    = rs1_data;
    ex_bus.pc          = pc;
    rs1_used           = 1'b1;
    rs2_used           = 1'b0;

    case (opcode)
      OPC_LUI: begin
        ex_bus.alu_op      = ALU_LUI;
        ex_bus.src2_is_imm = 1'b1;
        ex_bus.rf_we       = 1'b1;
        ex_bus.imm         = imm_u;
        rs1_used           = 1'b0;
      end
      OPC_AUIPC: begin
        ex_bus.src1_is_pc  = 1'b1;
        ex_bus.src2_is_imm = 1'b1;
        ex_bus.rf_we       = 1'b1;
        ex_bus.imm         = imm_u;
        rs1_used           = 1'b0;
      end
      OPC_JAL: begin
        ex_bus.src1_is_pc  = 1'b1;
        ex_bus.src2_is_imm = 1'b1;
        ex_bus.rf_we       = 1'b1;
        ex_bus.imm         = imm_j;
        rs1_used           = 1'b0;
      end
      OPC_JALR: begin
        ex_bus.src2_is_imm = 1'b1;
        ex_bus.rf_we       = 1'b1;
        ex_bus.imm         = imm_i;
      end
      OPC_BRANCH: begin
        ex_bus.alu_op = ALU_SUB;
        ex_bus.imm    = imm_b;
        rs2_used      = 1'b1;
      end
      OPC_LOAD: begin
        ex_bus.src2_is_imm = 1'b1;
        ex_bus.mem_re      = 1'b1;
        ex_bus.rf_we       = 1'b1;
        ex_bus.imm         = imm_i;
      end
      OPC_STORE: begin
        ex_bus.src2_is_imm = 1'b1;
        ex_bus.mem_we      = 1'b1;
        ex_bus.imm         = imm_s;
        rs2_used           = 1'b1;
      end
      OPC_OP_IMM: begin
        ex_bus.alu_op      = alu_from_funct3(funct3, inst[30] && (funct3 == 3'b101));
        ex_bus.src2_is_imm = 1'b1;
        ex_bus.rf_we       = 1'b1;
        ex_bus.imm         = imm_i;
      end
      OPC_OP: begin
        rs2_used = 1'b1;
        if (op_funct7_ok) begin
          ex_bus.alu_op = alu_from_funct3(funct3, inst[30]);
          ex_bus.rf_we  = 1'b1;
        end else begin
          ex_bus.illegal = 1'b1;
        end
      end
      default: begin
        ex_bus.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard testbench for id_stage: stimulus pushes hand-computed ID->EX
// bundles, a negedge monitor pops and compares each one as it issues.
`timescale 1ns/1ps
module tb_id_stage;
  import id_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fs_to_ds_valid;
  logic         ds_allowin;
  logic [63:0]  if_id_bus_in;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [145:0] id_ex_bus_out;
  logic         flush;
  logic [4:0]   es_dest;
  logic [4:0]   ms_dest;
  logic         ws_rf_we;
  logic [4:0]   ws_rf_waddr;
  logic [31:0]  ws_rf_wdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    logic [145:0] exp;
    logic [145:0] mask;
  } exp_t;

  exp_t sb_q[$];

  logic [145:0] m_full;
  logic [145:0] m_no_imm;
  logic [145:0] m_no_rd;
  logic [145:0] m_illegal;

  id_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fs_to_ds_valid (fs_to_ds_valid),
    .ds_allowin     (ds_allowin),
    .if_id_bus_in   (if_id_bus_in),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .id_ex_bus_out  (id_ex_bus_out),
    .flush          (flush),
    .es_dest        (es_dest),
    .ms_dest        (ms_dest),
    .ws_rf_we       (ws_rf_we),
    .ws_rf_waddr    (ws_rf_waddr),
    .ws_rf_wdata    (ws_rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [145:0] mkBus(
    input logic ill, input logic [3:0] alu, input logic s1pc, input logic s2imm,
    input logic [2:0] f3, input logic re, input logic we, input logic rfwe,
    input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] rs2d,
    input logic [31:0] rs1d, input logic [31:0] pc);
    return {ill, alu, s1pc, s2imm, f3, re, we, rfwe, rd, imm, rs2d, rs1d, pc};
  endfunction

  task automatic checkOutput(input string name, input logic [145:0] act,
                             input logic [145:0] exp, input logic [145:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h (mask %h)", name, act & mask, exp & mask, mask);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {145'd0, act}, {145'd0, exp}, {145'd0, 1'b1});
  endtask

  task automatic wbWrite(input logic [4:0] addr, input logic [31:0] data);
    ws_rf_we    = 1'b1;
    ws_rf_waddr = addr;
    ws_rf_wdata = data;
    @(posedge clk); #1;
    ws_rf_we    = 1'b0;
  endtask

  // Presents one instruction until ID accepts it; optionally records its expected issue.
  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc, input bit push,
                               input string name, input logic [145:0] exp, input logic [145:0] mask);
    int n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    fs_to_ds_valid = 1'b1;
    if_id_bus_in   = {inst, pc};
    while (!acc && n < 20) begin
      @(negedge clk);
      if (ds_allowin) begin
        acc = 1'b1;
        if (push) sb_q.push_back('{name, exp, mask});
      end
      @(posedge clk); #1;
      n++;
    end
    fs_to_ds_valid = 1'b0;
    checkBit({name, "_accepted"}, acc, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checkBit({name, "_issued"}, sb_q.size() == 0, 1'b1);
  endtask

  // Monitor: every handshake into EX must match the oldest expected bundle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && ds_to_es_valid && es_allowin) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_issue: got bus %h, want no issue", id_ex_bus_out);
      end else begin
        e = sb_q.pop_front();
        checkOutput(e.name, id_ex_bus_out, e.exp, e.mask);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    m_full    = '1;
    m_no_imm  = ~mkBus(0, 4'h0, 0, 0, 3'h0, 0, 0, 0, 5'h00, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    m_no_rd   = ~mkBus(0, 4'h0, 0, 0, 3'h0, 0, 0, 0, 5'h1F, 32'h0, 32'h0, 32'h0, 32'h0);
    m_illegal =  mkBus(1, 4'h0, 0, 0, 3'h0, 1, 1, 1, 5'h00, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);

    rst_n = 1'b0; fs_to_ds_valid = 1'b0; if_id_bus_in = '0; es_allowin = 1'b1;
    flush = 1'b0; es_dest = '0; ms_dest = '0;
    ws_rf_we = 1'b0; ws_rf_waddr = '0; ws_rf_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    checkBit("reset_allowin", ds_allowin, 1'b1);
    checkBit("reset_no_issue", ds_to_es_valid, 1'b0);
    rst_n = 1'b1;

    wbWrite(5'd5, 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h00A28293, 32'h80, 1'b1, "x5_cleared_by_reset",
                  mkBus(0, ALU_ADD, 0, 1, 3'd0, 0, 0, 1, 5'd5, 32'd10, 32'd0, 32'd0, 32'h80), m_full);
    drain("x5_cleared_by_reset");

    wbWrite(5'd5, 32'd7);
    applyStimulus(32'h00A28293, 32'h100, 1'b1, "addi_basic",
                  mkBus(0, ALU_ADD, 0, 1, 3'd0, 0, 0, 1, 5'd5, 32'd10, 32'd0, 32'd7, 32'h100), m_full);
    drain("addi_basic");

    es_allowin = 1'b0;
    applyStimulus(32'h00100313, 32'h104, 1'b1, "bp_held",
                  mkBus(0, ALU_ADD, 0, 1, 3'd0, 0, 0, 1, 5'd6, 32'd1, 32'd0, 32'd0, 32'h104), m_full);
    fs_to_ds_valid = 1'b1;
    if_id_bus_in   = {32'h00200393, 32'h108};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBit("bp_allowin_low", ds_allowin, 1'b0);
      checkOutput("bp_bus_stable", id_ex_bus_out,
                  mkBus(0, ALU_ADD, 0, 1, 3'd0, 0, 0, 1, 5'd6, 32'd1, 32'd0, 32'd0, 32'h104), m_full);
      @(posedge clk); #1;
    end
    es_allowin = 1'b1;
    @(negedge clk);
    checkBit("bp_release_allowin", ds_allowin, 1'b1);
    sb_q.push_back('{"bp_next", mkBus(0, ALU_ADD, 0, 1, 3'd0, 0, 0, 1, 5'd7, 32'd2, 32'd0, 32'd0, 32'h108), m_full});
    @(posedge clk); #1;
    fs_to_ds_valid = 1'b0;
    drain("bp_next");

    wbWrite(5'd6, 32'd3);
    es_dest = 5'd5;
    applyStimulus(32'h00628333, 32'h10C, 1'b1, "raw_add",
                  mkBus(0, ALU_ADD, 0, 0, 3'd0, 0, 0, 1, 5'd6, 32'd0, 32'd3, 32'd7, 32'h10C), m_no_imm);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkBit("raw_es_no_issue", ds_to_es_valid, 1'b0);
      checkBit("raw_es_allowin_low", ds_allowin, 1'b0);
      @(posedge clk); #1;
    end
    es_dest = 5'd0;
    ms_dest = 5'd6;
    @(negedge clk);
    checkBit("raw_ms_rs2_no_issue", ds_to_es_valid, 1'b0);
    @(posedge clk); #1;
    ms_dest = 5'd0;
    @(negedge clk);
    checkBit("raw_release_issue", ds_to_es_valid, 1'b1);
    @(posedge clk); #1;
    drain("raw_add");

    applyStimulus(32'h00100313, 32'h110, 1'b1, "x0_src_no_stall",
                  mkBus(0, ALU_ADD, 0, 1, 3'd0, 0, 0, 1, 5'd6, 32'd1, 32'd0, 32'd0, 32'h110), m_full);
    @(negedge clk);
    checkBit("x0_src_issue_now", ds_to_es_valid, 1'b1);
    @(posedge clk); #1;
    drain("x0_src_no_stall");

    es_allowin = 1'b0;
    applyStimulus(32'h00200393, 32'h114, 1'b0, "flush_victim", '0, '0);
    fs_to_ds_valid = 1'b1;
    if_id_bus_in   = {32'h00100313, 32'h118};
    flush          = 1'b1;
    @(negedge clk);
    checkBit("flush_kills_issue", ds_to_es_valid, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; fs_to_ds_valid = 1'b0; es_allowin = 1'b1;
    @(negedge clk);
    checkBit("flush_clears_valid", ds_to_es_valid, 1'b0);
    checkBit("flush_allowin", ds_allowin, 1'b1);
    @(posedge clk); #1;

    applyStimulus(32'hFE000EE3, 32'h200, 1'b1, "beq_neg_offset",
                  mkBus(0, ALU_SUB, 0, 0, 3'd0, 0, 0, 0, 5'd0, 32'hFFFFFFFC, 32'd0, 32'd0, 32'h200), m_no_rd);
    drain("beq_neg_offset");

    applyStimulus(32'h0000007F, 32'h204, 1'b1, "illegal_opcode",
                  mkBus(1, 4'h0, 0, 0, 3'd0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h204), m_illegal);
    drain("illegal_opcode");

    ws_rf_we = 1'b1; ws_rf_waddr = 5'd0; ws_rf_wdata = 32'hDEAD;
    applyStimulus(32'h00100313, 32'h208, 1'b1, "x0_write_ignored",
                  mkBus(0, ALU_ADD, 0, 1, 3'd0, 0, 0, 1, 5'd6, 32'd1, 32'd0, 32'd0, 32'h208), m_full);
    drain("x0_write_ignored");
    ws_rf_we = 1'b0;

    es_allowin = 1'b0;
    applyStimulus(32'h00538413, 32'h20C, 1'b1, "bypass_x7",
                  mkBus(0, ALU_ADD, 0, 1, 3'd0, 0, 0, 1, 5'd8, 32'd5, 32'd7, 32'h1234, 32'h20C), m_full);
    ws_rf_we = 1'b1; ws_rf_waddr = 5'd7; ws_rf_wdata = 32'h1234;
    es_allowin = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    ws_rf_we = 1'b0;
    drain("bypass_x7");

    es_dest = 5'd7;
    applyStimulus(32'h00538413, 32'h210, 1'b0, "stalled_victim", '0, '0);
    @(negedge clk);
    checkBit("stall_before_reset", ds_allowin, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkBit("reset_midstall_allowin", ds_allowin, 1'b1);
    checkBit("reset_midstall_no_issue", ds_to_es_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    es_dest = 5'd0;
    @(negedge clk);
    checkBit("after_reset_no_issue", ds_to_es_valid, 1'b0);
    @(posedge clk); #1;

    checkBit("scoreboard_empty", sb_q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
